// File: rtl/id_ex_stage_reg_if.sv
// ID->EX pipeline bundle: ID-side decoded fields and stage controls in, registered EX-side fields out.
// Extra source-register fields for the forwarding unit exist only when FORWARDING_EN is defined.
interface id_ex_stage_reg_if #(
  parameter int DATA_W       = 32,
  parameter int SQUASH_CNT_W = 16
);
  // Stage controls
  logic                    freeze;
  logic                    flush;
  logic                    cond_pass;

  // ID side
  logic                    id_valid;
  logic [DATA_W-1:0]       id_pc;
  logic                    id_wb_en;
  logic                    id_mem_r;
  logic                    id_mem_w;
  logic                    id_b;
  logic                    id_s;
  logic                    id_imm;
  logic [3:0]              id_exe_cmd;
  logic [DATA_W-1:0]       id_val_rn;
  logic [DATA_W-1:0]       id_val_rm;
  logic [11:0]             id_shift_operand;
  logic [23:0]             id_signed_imm24;
  logic [3:0]              id_dest;
  logic [3:0]              id_status;

  // EX side
  logic                    ex_valid;
  logic [DATA_W-1:0]       ex_pc;
  logic                    ex_wb_en;
  logic                    ex_mem_r;
  logic                    ex_mem_w;
  logic                    ex_b;
  logic                    ex_s;
  logic                    ex_imm;
  logic [3:0]              ex_exe_cmd;
  logic [DATA_W-1:0]       ex_val_rn;
  logic [DATA_W-1:0]       ex_val_rm;
  logic [11:0]             ex_shift_operand;
  logic [23:0]             ex_signed_imm24;
  logic [3:0]              ex_dest;
  logic [3:0]              ex_status;
  logic [SQUASH_CNT_W-1:0] squash_cnt;

`ifdef FORWARDING_EN
  logic [3:0]              id_src1;
  logic [3:0]              id_src2;
  logic                    id_two_src;
  logic [3:0]              ex_src1;
  logic [3:0]              ex_src2;
  logic                    ex_two_src;
`endif

  // Stage register view
  modport slave (
    input  freeze, flush, cond_pass,
    input  id_valid, id_pc, id_wb_en, id_mem_r, id_mem_w, id_b, id_s, id_imm,
    input  id_exe_cmd, id_val_rn, id_val_rm, id_shift_operand, id_signed_imm24,
    input  id_dest, id_status,
    output ex_valid, ex_pc, ex_wb_en, ex_mem_r, ex_mem_w, ex_b, ex_s, ex_imm,
    output ex_exe_cmd, ex_val_rn, ex_val_rm, ex_shift_operand, ex_signed_imm24,
    output ex_dest, ex_status, squash_cnt
`ifdef FORWARDING_EN
    ,
    input  id_src1, id_src2, id_two_src,
    output ex_src1, ex_src2, ex_two_src
`endif
  );

  // Driver view (ID stage / hazard unit side)
  modport master (
    output freeze, flush, cond_pass,
    output id_valid, id_pc, id_wb_en, id_mem_r, id_mem_w, id_b, id_s, id_imm,
    output id_exe_cmd, id_val_rn, id_val_rm, id_shift_operand, id_signed_imm24,
    output id_dest, id_status,
    input  ex_valid, ex_pc, ex_wb_en, ex_mem_r, ex_mem_w, ex_b, ex_s, ex_imm,
    input  ex_exe_cmd, ex_val_rn, ex_val_rm, ex_shift_operand, ex_signed_imm24,
    input  ex_dest, ex_status, squash_cnt
`ifdef FORWARDING_EN
    ,
    output id_src1, id_src2, id_two_src,
    input  ex_src1, ex_src2, ex_two_src
`endif
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with condition squash, flush bubble, freeze hold and a saturating squash counter.
// Optional macro FORWARDING_EN adds registered src1/src2/two_src fields for the forwarding unit.
module id_ex_stage_reg #(
  parameter int DATA_W       = 32,
  parameter int SQUASH_CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  id_ex_stage_reg_if.slave bus
);
  logic                    ex_valid_q;
  logic [DATA_W-1:0]       ex_pc_q;
  logic                    ex_wb_en_q;
  logic                    ex_mem_r_q;
  logic                    ex_mem_w_q;
  logic                    ex_b_q;
  logic                    ex_s_q;
  logic                    ex_imm_q;
  logic [3:0]              ex_exe_cmd_q;
  logic [DATA_W-1:0]       ex_val_rn_q;
  logic [DATA_W-1:0]       ex_val_rm_q;
  logic [11:0]             ex_shift_operand_q;
  logic [23:0]             ex_signed_imm24_q;
  logic [3:0]              ex_dest_q;
  logic [3:0]              ex_status_q;
  logic [SQUASH_CNT_W-1:0] squash_cnt_q;
`ifdef FORWARDING_EN
  logic [3:0]              ex_src1_q;
  logic [3:0]              ex_src2_q;
  logic                    ex_two_src_q;
`endif

  logic                    live;
  logic                    squash;
  logic                    capture;
  logic [SQUASH_CNT_W-1:0] squash_cnt_next;

  // cond_pass only reaches state through the capture branch, so an X on it
  // during reset/flush/freeze never lands in a register.
  always_comb begin
    capture         = !bus.flush && !bus.freeze;
    live            = bus.id_valid && bus.cond_pass;
    squash          = bus.id_valid && !bus.cond_pass;
    squash_cnt_next = squash_cnt_q;
    if (squash && (squash_cnt_q != '1)) begin
      squash_cnt_next = squash_cnt_q + SQUASH_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      ex_valid_q         <= 1'b0;
      ex_pc_q            <= '0;
      ex_wb_en_q         <= 1'b0;
      ex_mem_r_q         <= 1'b0;
      ex_mem_w_q         <= 1'b0;
      ex_b_q             <= 1'b0;
      ex_s_q             <= 1'b0;
      ex_imm_q           <= 1'b0;
      ex_exe_cmd_q       <= '0;
      ex_val_rn_q        <= '0;
      ex_val_rm_q        <= '0;
      ex_shift_operand_q <= '0;
      ex_signed_imm24_q  <= '0;
      ex_dest_q          <= '0;
      ex_status_q        <= '0;
`ifdef FORWARDING_EN
      ex_src1_q          <= '0;
      ex_src2_q          <= '0;
      ex_two_src_q       <= 1'b0;
`endif
    end else if (!bus.freeze) begin
      // Side-effecting controls are gated by liveness; operand fields are
      // always copied so a killed instruction stays visible in EX.
      ex_valid_q         <= live;
      ex_pc_q            <= bus.id_pc;
      ex_wb_en_q         <= bus.id_wb_en && live;
      ex_mem_r_q         <= bus.id_mem_r && live;
      ex_mem_w_q         <= bus.id_mem_w && live;
      ex_b_q             <= bus.id_b && live;
      ex_s_q             <= bus.id_s && live;
      ex_imm_q           <= bus.id_imm;
      ex_exe_cmd_q       <= bus.id_exe_cmd;
      ex_val_rn_q        <= bus.id_val_rn;
      ex_val_rm_q        <= bus.id_val_rm;
      ex_shift_operand_q <= bus.id_shift_operand;
      ex_signed_imm24_q  <= bus.id_signed_imm24;
      ex_dest_q          <= bus.id_dest;
      ex_status_q        <= bus.id_status;
`ifdef FORWARDING_EN
      ex_src1_q          <= bus.id_src1;
      ex_src2_q          <= bus.id_src2;
      ex_two_src_q       <= bus.id_two_src && live;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      squash_cnt_q <= '0;
    end else if (capture) begin
      squash_cnt_q <= squash_cnt_next;
    end
  end

  assign bus.ex_valid         = ex_valid_q;
  assign bus.ex_pc            = ex_pc_q;
  assign bus.ex_wb_en         = ex_wb_en_q;
  assign bus.ex_mem_r         = ex_mem_r_q;
  assign bus.ex_mem_w         = ex_mem_w_q;
  assign bus.ex_b             = ex_b_q;
  assign bus.ex_s             = ex_s_q;
  assign bus.ex_imm           = ex_imm_q;
  assign bus.ex_exe_cmd       = ex_exe_cmd_q;
  assign bus.ex_val_rn        = ex_val_rn_q;
  assign bus.ex_val_rm        = ex_val_rm_q;
  assign bus.ex_shift_operand = ex_shift_operand_q;
  assign bus.ex_signed_imm24  = ex_signed_imm24_q;
  assign bus.ex_dest          = ex_dest_q;
  assign bus.ex_status        = ex_status_q;
  assign bus.squash_cnt       = squash_cnt_q;
`ifdef FORWARDING_EN
  assign bus.ex_src1          = ex_src1_q;
  assign bus.ex_src2          = ex_src2_q;
  assign bus.ex_two_src       = ex_two_src_q;
`endif
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed literal checks plus a randomized run against a behavioural model.
// A second instance with a 2-bit squash counter shares the stimulus to exercise saturation.
module tb_id_ex_stage_reg;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst;

  id_ex_stage_reg_if #(.DATA_W(DATA_W), .SQUASH_CNT_W(16)) bus0 ();
  id_ex_stage_reg_if #(.DATA_W(DATA_W), .SQUASH_CNT_W(2))  bus1 ();

  assign bus1.freeze           = bus0.freeze;
  assign bus1.flush            = bus0.flush;
  assign bus1.cond_pass        = bus0.cond_pass;
  assign bus1.id_valid         = bus0.id_valid;
  assign bus1.id_pc            = bus0.id_pc;
  assign bus1.id_wb_en         = bus0.id_wb_en;
  assign bus1.id_mem_r         = bus0.id_mem_r;
  assign bus1.id_mem_w         = bus0.id_mem_w;
  assign bus1.id_b             = bus0.id_b;
  assign bus1.id_s             = bus0.id_s;
  assign bus1.id_imm           = bus0.id_imm;
  assign bus1.id_exe_cmd       = bus0.id_exe_cmd;
  assign bus1.id_val_rn        = bus0.id_val_rn;
  assign bus1.id_val_rm        = bus0.id_val_rm;
  assign bus1.id_shift_operand = bus0.id_shift_operand;
  assign bus1.id_signed_imm24  = bus0.id_signed_imm24;
  assign bus1.id_dest          = bus0.id_dest;
  assign bus1.id_status        = bus0.id_status;
`ifdef FORWARDING_EN
  assign bus1.id_src1          = bus0.id_src1;
  assign bus1.id_src2          = bus0.id_src2;
  assign bus1.id_two_src       = bus0.id_two_src;
`endif

  id_ex_stage_reg #(.DATA_W(DATA_W), .SQUASH_CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  id_ex_stage_reg #(.DATA_W(DATA_W), .SQUASH_CNT_W(2))  dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic              wb_en;
    logic              mem_r;
    logic              mem_w;
    logic              b;
    logic              s;
    logic              imm;
    logic [3:0]        exe_cmd;
    logic [11:0]       shift_operand;
    logic [23:0]       imm24;
    logic [3:0]        dest;
    logic [3:0]        status;
`ifdef FORWARDING_EN
    logic [3:0]        src1;
    logic [3:0]        src2;
    logic              two_src;
`endif
    logic [15:0]       cnt;
    logic [1:0]        cnt2;
  } ex_t;
  localparam int W = $bits(ex_t);

  logic [W-1:0] exp_q[$];
  ex_t          model;
  int unsigned  sq_count;
  int           checks   = 0;
  int           failures = 0;

  function automatic ex_t dut_vec();
    ex_t v;
    v.valid         = bus0.ex_valid;
    v.pc            = bus0.ex_pc;
    v.val_rn        = bus0.ex_val_rn;
    v.val_rm        = bus0.ex_val_rm;
    v.wb_en         = bus0.ex_wb_en;
    v.mem_r         = bus0.ex_mem_r;
    v.mem_w         = bus0.ex_mem_w;
    v.b             = bus0.ex_b;
    v.s             = bus0.ex_s;
    v.imm           = bus0.ex_imm;
    v.exe_cmd       = bus0.ex_exe_cmd;
    v.shift_operand = bus0.ex_shift_operand;
    v.imm24         = bus0.ex_signed_imm24;
    v.dest          = bus0.ex_dest;
    v.status        = bus0.ex_status;
`ifdef FORWARDING_EN
    v.src1          = bus0.ex_src1;
    v.src2          = bus0.ex_src2;
    v.two_src       = bus0.ex_two_src;
`endif
    v.cnt           = bus0.squash_cnt;
    v.cnt2          = bus1.squash_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: one compare every cycle against the oldest prediction
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      ex_t e;
      ex_t a;
      e = ex_t'(exp_q.pop_front());
      a = dut_vec();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t actual=%h required=%h", $time, a, e);
      end
    end
  end

  // Predict the state after the coming rising edge, then let the edge happen.
  task automatic cycle();
    ex_t  nx;
    logic live;
    logic squash;
    nx = model;
    if (rst) begin
      nx       = '0;
      sq_count = 0;
    end else if (bus0.flush) begin
      nx = '0;
    end else if (!bus0.freeze) begin
      live             = bus0.id_valid && bus0.cond_pass;
      squash           = bus0.id_valid && !bus0.cond_pass;
      nx.valid         = live;
      nx.pc            = bus0.id_pc;
      nx.val_rn        = bus0.id_val_rn;
      nx.val_rm        = bus0.id_val_rm;
      nx.wb_en         = live ? bus0.id_wb_en : 1'b0;
      nx.mem_r         = live ? bus0.id_mem_r : 1'b0;
      nx.mem_w         = live ? bus0.id_mem_w : 1'b0;
      nx.b             = live ? bus0.id_b : 1'b0;
      nx.s             = live ? bus0.id_s : 1'b0;
      nx.imm           = bus0.id_imm;
      nx.exe_cmd       = bus0.id_exe_cmd;
      nx.shift_operand = bus0.id_shift_operand;
      nx.imm24         = bus0.id_signed_imm24;
      nx.dest          = bus0.id_dest;
      nx.status        = bus0.id_status;
`ifdef FORWARDING_EN
      nx.src1          = bus0.id_src1;
      nx.src2          = bus0.id_src2;
      nx.two_src       = live ? bus0.id_two_src : 1'b0;
`endif
      if (squash) sq_count++;
    end
    nx.cnt  = (sq_count > 65535) ? 16'hffff : 16'(sq_count);
    nx.cnt2 = (sq_count > 3) ? 2'd3 : 2'(sq_count);
    model   = nx;
    exp_q.push_back(W'(nx));
    @(negedge clk);
  endtask

  // Driver tasks
  task automatic rand_id();
    bus0.id_valid         = ($urandom_range(0, 9) < 8);
    bus0.id_pc            = $urandom();
    bus0.id_wb_en         = 1'($urandom_range(0, 1));
    bus0.id_mem_r         = 1'($urandom_range(0, 1));
    bus0.id_mem_w         = 1'($urandom_range(0, 1));
    bus0.id_b             = 1'($urandom_range(0, 1));
    bus0.id_s             = 1'($urandom_range(0, 1));
    bus0.id_imm           = 1'($urandom_range(0, 1));
    bus0.id_exe_cmd       = 4'($urandom_range(0, 15));
    bus0.id_val_rn        = $urandom();
    bus0.id_val_rm        = $urandom();
    bus0.id_shift_operand = 12'($urandom());
    bus0.id_signed_imm24  = 24'($urandom());
    bus0.id_dest          = 4'($urandom_range(0, 15));
    bus0.id_status        = 4'($urandom_range(0, 15));
`ifdef FORWARDING_EN
    bus0.id_src1          = 4'($urandom_range(0, 15));
    bus0.id_src2          = 4'($urandom_range(0, 15));
    bus0.id_two_src       = 1'($urandom_range(0, 1));
`endif
  endtask

  task automatic clear_id();
    bus0.id_valid         = 1'b0;
    bus0.id_pc            = '0;
    bus0.id_wb_en         = 1'b0;
    bus0.id_mem_r         = 1'b0;
    bus0.id_mem_w         = 1'b0;
    bus0.id_b             = 1'b0;
    bus0.id_s             = 1'b0;
    bus0.id_imm           = 1'b0;
    bus0.id_exe_cmd       = '0;
    bus0.id_val_rn        = '0;
    bus0.id_val_rm        = '0;
    bus0.id_shift_operand = '0;
    bus0.id_signed_imm24  = '0;
    bus0.id_dest          = '0;
    bus0.id_status        = '0;
`ifdef FORWARDING_EN
    bus0.id_src1          = '0;
    bus0.id_src2          = '0;
    bus0.id_two_src       = 1'b0;
`endif
  endtask

  initial begin
    model    = '0;
    sq_count = 0;
    rst         = 1'b1;
    bus0.flush  = 1'b0;
    bus0.freeze = 1'b0;

    // Reset with random ID activity and an unknown condition result
    for (int i = 0; i < 2; i++) begin
      rand_id();
      bus0.cond_pass = 1'bx;
      cycle();
    end
    check("reset_valid", 64'(bus0.ex_valid), 64'd0);
    check("reset_pc", 64'(bus0.ex_pc), 64'd0);
    check("reset_wb_en", 64'(bus0.ex_wb_en), 64'd0);
    check("reset_cnt", 64'(bus0.squash_cnt), 64'd0);

    // Passing capture
    rst = 1'b0;
    clear_id();
    bus0.id_valid   = 1'b1;
    bus0.cond_pass  = 1'b1;
    bus0.id_pc      = 32'h14;
    bus0.id_wb_en   = 1'b1;
    bus0.id_exe_cmd = 4'b0010;
    bus0.id_val_rn  = 32'd5;
    bus0.id_dest    = 4'd3;
    cycle();
    check("pass_valid", 64'(bus0.ex_valid), 64'd1);
    check("pass_pc", 64'(bus0.ex_pc), 64'h14);
    check("pass_wb_en", 64'(bus0.ex_wb_en), 64'd1);
    check("pass_exe_cmd", 64'(bus0.ex_exe_cmd), 64'd2);
    check("pass_val_rn", 64'(bus0.ex_val_rn), 64'd5);
    check("pass_dest", 64'(bus0.ex_dest), 64'd3);

    // Squash: controls killed, data still visible, counter bumps
    bus0.cond_pass = 1'b0;
    bus0.id_mem_w  = 1'b1;
    bus0.id_s      = 1'b1;
    bus0.id_status = 4'b1010;
    cycle();
    check("squash_valid", 64'(bus0.ex_valid), 64'd0);
    check("squash_wb_en", 64'(bus0.ex_wb_en), 64'd0);
    check("squash_mem_w", 64'(bus0.ex_mem_w), 64'd0);
    check("squash_s", 64'(bus0.ex_s), 64'd0);
    check("squash_pc", 64'(bus0.ex_pc), 64'h14);
    check("squash_status", 64'(bus0.ex_status), 64'hA);
    check("squash_cnt", 64'(bus0.squash_cnt), 64'd1);

    // Freeze holds everything while inputs churn
    bus0.freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      bus0.cond_pass = 1'bx;
      cycle();
      check("freeze_pc", 64'(bus0.ex_pc), 64'h14);
      check("freeze_cnt", 64'(bus0.squash_cnt), 64'd1);
    end

    // Flush wins over freeze
    bus0.flush = 1'b1;
    rand_id();
    bus0.cond_pass = 1'bx;
    cycle();
    check("flush_valid", 64'(bus0.ex_valid), 64'd0);
    check("flush_pc", 64'(bus0.ex_pc), 64'd0);
    check("flush_wb_en", 64'(bus0.ex_wb_en), 64'd0);
    check("flush_cnt", 64'(bus0.squash_cnt), 64'd1);

    // Five squashes: narrow counter saturates at 3
    bus0.flush  = 1'b0;
    bus0.freeze = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_id();
      bus0.id_valid  = 1'b1;
      bus0.cond_pass = 1'b0;
      cycle();
    end
    check("sat_cnt2", 64'(bus1.squash_cnt), 64'd3);
    check("sat_cnt16", 64'(bus0.squash_cnt), 64'd6);
    rst = 1'b1;
    cycle();
    check("sat_reset_cnt2", 64'(bus1.squash_cnt), 64'd0);
    rst = 1'b0;

`ifdef FORWARDING_EN
    clear_id();
    bus0.id_valid   = 1'b1;
    bus0.cond_pass  = 1'b1;
    bus0.id_src1    = 4'd7;
    bus0.id_src2    = 4'd9;
    bus0.id_two_src = 1'b1;
    cycle();
    check("fwd_src1", 64'(bus0.ex_src1), 64'd7);
    check("fwd_src2", 64'(bus0.ex_src2), 64'd9);
    check("fwd_two_src", 64'(bus0.ex_two_src), 64'd1);
    bus0.cond_pass = 1'b0;
    cycle();
    check("fwd_squash_two_src", 64'(bus0.ex_two_src), 64'd0);
    check("fwd_squash_src1", 64'(bus0.ex_src1), 64'd7);
`endif

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      bus0.flush  = ($urandom_range(0, 9) == 0);
      bus0.freeze = ($urandom_range(0, 4) == 0);
      rand_id();
      if (rst || bus0.flush || bus0.freeze) bus0.cond_pass = 1'bx;
      else bus0.cond_pass = ($urandom_range(0, 9) < 7);
      cycle();
    end

    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
